unary_seg_ramp: RTL and testbench



---
 rtl/seg_ramp_pkg.sv | 21 ++
 rtl/seg_step_timer.sv | 28 ++
 rtl/unary_seg_ramp.sv | 88 ++++++++
 tb/tb_unary_seg_ramp.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/seg_ramp_pkg.sv
// Shared types and helpers for the unary segment ramp controller.
// Functions work on a 64-bit maximum width; callers slice to NSEG.
package seg_ramp_pkg;

    typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

    localparam int unsigned MAXSEG = 64;

    function automatic logic [MAXSEG-1:0] bin2therm(input int unsigned code);
        logic [MAXSEG-1:0] t;
        t = '0;
        for (int unsigned i = 0; i < MAXSEG; i++)
            t[i] = (i < code);
        return t;
    endfunction

    function automatic int unsigned sat_code(input int unsigned code, input int unsigned nseg);
        return (code > nseg) ? nseg : code;
    endfunction

endpackage

// File: rtl/seg_step_timer.sv
// Step interval timer: reloads to STEP_CYC-1, counts down to zero, holds on freeze.
// expire is high when a step may be taken this cycle.
module seg_step_timer #(
    parameter int STEP_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic freeze,
    output logic expire
);
    localparam int TW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam logic [TW-1:0] RELOAD = TW'(STEP_CYC - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= RELOAD;
        else if (!freeze && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expire = (cnt == '0) && !freeze;

endmodule

// File: rtl/unary_seg_ramp.sv
// Thermometer gate-enable controller: ramps the enabled segment count toward an
// accepted target one segment per STEP_CYC cycles, or jumps there in immediate mode.
module unary_seg_ramp
    import seg_ramp_pkg::*;
#(
    parameter int NSEG     = 3,
    parameter int STEP_CYC = 4,
    localparam int CW      = $clog2(NSEG + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CW-1:0]   tgt_code,
    input  logic            tgt_imm,
    input  logic            tgt_valid,
    output logic            tgt_ready,
    input  logic            freeze,
    output logic [NSEG-1:0] seg_en,
    output logic [CW-1:0]   cur_code,
    output logic            busy,
    output logic            done
);
    state_t          state, state_nxt;
    logic [CW-1:0]   tgt_q, tgt_sat, code_nxt;
    logic            accept, go_ramp, step, last_step, expire;
    logic [MAXSEG-1:0] therm;

    assign accept    = tgt_valid && (state == IDLE);
    assign tgt_sat   = CW'(sat_code(32'(tgt_code), NSEG));
    assign go_ramp   = accept && !tgt_imm && (tgt_sat != cur_code);
    assign step      = (state == RAMP) && expire;
    assign code_nxt  = (tgt_q > cur_code) ? cur_code + 1'b1 : cur_code - 1'b1;
    assign last_step = step && (code_nxt == tgt_q);

    seg_step_timer #(.STEP_CYC(STEP_CYC)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (go_ramp || step),
        .freeze (freeze),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (go_ramp)   state_nxt = RAMP;
            RAMP: if (last_step) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tgt_ready = (state == IDLE);
        busy      = (state == RAMP);
    end

    // No-op and immediate requests complete at the acceptance edge itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_code <= '0;
            tgt_q    <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                tgt_q <= tgt_sat;
                if (tgt_imm || tgt_sat == cur_code) begin
                    cur_code <= tgt_sat;
                    done     <= 1'b1;
                end
            end
            if (step) begin
                cur_code <= code_nxt;
                done     <= last_step;
            end
        end
    end

    assign therm  = bin2therm(32'(cur_code));
    assign seg_en = therm[NSEG-1:0];

endmodule

// File: tb/tb_unary_seg_ramp.sv
// Directed bench for unary_seg_ramp: three instances cover (NSEG,STEP_CYC) =
// (3,4), (5,2), (8,1). Inputs change and outputs are sampled 1ns after posedge.
module tb_unary_seg_ramp;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Instance A: NSEG=3, STEP_CYC=4
    logic       rst_a, imm_a, vld_a, rdy_a, frz_a, busy_a, done_a;
    logic [1:0] code_a, cur_a;
    logic [2:0] seg_a;
    unary_seg_ramp #(.NSEG(3), .STEP_CYC(4)) u_a (
        .clk(clk), .rst(rst_a), .tgt_code(code_a), .tgt_imm(imm_a), .tgt_valid(vld_a),
        .tgt_ready(rdy_a), .freeze(frz_a), .seg_en(seg_a), .cur_code(cur_a),
        .busy(busy_a), .done(done_a));

    // Instance B: NSEG=5, STEP_CYC=2
    logic       rst_b, imm_b, vld_b, rdy_b, frz_b, busy_b, done_b;
    logic [2:0] code_b, cur_b;
    logic [4:0] seg_b;
    unary_seg_ramp #(.NSEG(5), .STEP_CYC(2)) u_b (
        .clk(clk), .rst(rst_b), .tgt_code(code_b), .tgt_imm(imm_b), .tgt_valid(vld_b),
        .tgt_ready(rdy_b), .freeze(frz_b), .seg_en(seg_b), .cur_code(cur_b),
        .busy(busy_b), .done(done_b));

    // Instance C: NSEG=8, STEP_CYC=1
    logic       rst_c, imm_c, vld_c, rdy_c, frz_c, busy_c, done_c;
    logic [3:0] code_c, cur_c;
    logic [7:0] seg_c;
    unary_seg_ramp #(.NSEG(8), .STEP_CYC(1)) u_c (
        .clk(clk), .rst(rst_c), .tgt_code(code_c), .tgt_imm(imm_c), .tgt_valid(vld_c),
        .tgt_ready(rdy_c), .freeze(frz_c), .seg_en(seg_c), .cur_code(cur_c),
        .busy(busy_c), .done(done_c));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] therm(input int n);
        return (32'd1 << n) - 32'd1;
    endfunction

    int cnt;

    initial begin
        rst_a = 1; imm_a = 0; vld_a = 0; frz_a = 0; code_a = '0;
        rst_b = 1; imm_b = 0; vld_b = 0; frz_b = 0; code_b = '0;
        rst_c = 1; imm_c = 0; vld_c = 0; frz_c = 0; code_c = '0;
        // request presented during reset must be discarded
        vld_a = 1; code_a = 2'd2; imm_a = 1;
        tick();
        tick();
        chk("rst_seg", 32'(seg_a), 32'h0);
        chk("rst_cur", 32'(cur_a), 32'h0);
        chk("rst_busy", 32'(busy_a), 32'h0);
        chk("rst_done", 32'(done_a), 32'h0);
        chk("rst_ready", 32'(rdy_a), 32'h1);
        vld_a = 0; imm_a = 0;
        rst_a = 0; rst_b = 0; rst_c = 0;
        tick();
        chk("rst_discard", 32'(cur_a), 32'h0);

        // A: ramp 0 -> 3, steps at E0+4, E0+8, E0+12
        code_a = 2'd3; vld_a = 1;
        tick();
        vld_a = 0;
        chk("up_busy0", 32'(busy_a), 32'h1);
        chk("up_rdy0", 32'(rdy_a), 32'h0);
        for (int k = 1; k <= 13; k++) begin
            tick();
            cnt = (k / 4 > 3) ? 3 : k / 4;
            chk($sformatf("up_seg%0d", k), 32'(seg_a), therm(cnt));
            chk($sformatf("up_busy%0d", k), 32'(busy_a), 32'(k < 12));
            chk($sformatf("up_done%0d", k), 32'(done_a), 32'(k == 12));
        end

        // A: ramp 3 -> 1, freeze high for edges E0+3..E0+5
        code_a = 2'd1; vld_a = 1;
        tick();
        vld_a = 0;
        for (int k = 1; k <= 12; k++) begin
            frz_a = (k >= 3 && k <= 5);
            tick();
            cnt = (k < 7) ? 3 : (k < 11) ? 2 : 1;
            chk($sformatf("dn_seg%0d", k), 32'(seg_a), therm(cnt));
            chk($sformatf("dn_rdy%0d", k), 32'(rdy_a), 32'(k >= 11));
            chk($sformatf("dn_done%0d", k), 32'(done_a), 32'(k == 11));
        end
        frz_a = 0;

        // A: no-op requests held valid -> done every cycle, seg stable
        code_a = 2'd1; vld_a = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("noop_done", 32'(done_a), 32'h1);
            chk("noop_seg", 32'(seg_a), 32'h1);
            chk("noop_busy", 32'(busy_a), 32'h0);
        end

        // A: ramp 1 -> 3 with an immediate 0 request held through the ramp
        code_a = 2'd3; imm_a = 0;
        tick();
        code_a = 2'd0; imm_a = 1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("b2b_rdy%0d", k), 32'(rdy_a), 32'(k == 8));
        end
        chk("b2b_seg_top", 32'(seg_a), 32'h7);
        chk("b2b_done_ramp", 32'(done_a), 32'h1);
        tick();
        vld_a = 0; imm_a = 0;
        chk("b2b_seg_imm", 32'(seg_a), 32'h0);
        chk("b2b_done_imm", 32'(done_a), 32'h1);
        tick();
        chk("b2b_done_clr", 32'(done_a), 32'h0);

        // A: reset at E0+6 of a 0 -> 3 ramp
        code_a = 2'd3; vld_a = 1;
        tick();
        vld_a = 0;
        for (int k = 1; k <= 5; k++) tick();
        chk("mid_seg_pre", 32'(seg_a), 32'h1);
        rst_a = 1;
        tick();
        rst_a = 0;
        chk("mid_seg", 32'(seg_a), 32'h0);
        chk("mid_busy", 32'(busy_a), 32'h0);
        chk("mid_rdy", 32'(rdy_a), 32'h1);
        chk("mid_done", 32'(done_a), 32'h0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("mid_nodone", 32'(done_a), 32'h0);
            chk("mid_seg_hold", 32'(seg_a), 32'h0);
        end

        // B: immediate with saturation 7 -> 5
        code_b = 3'd7; imm_b = 1; vld_b = 1;
        tick();
        vld_b = 0; imm_b = 0;
        chk("imm_seg", 32'(seg_b), 32'h1f);
        chk("imm_cur", 32'(cur_b), 32'd5);
        chk("imm_done", 32'(done_b), 32'h1);
        chk("imm_busy", 32'(busy_b), 32'h0);
        tick();
        chk("imm_done_clr", 32'(done_b), 32'h0);
        chk("imm_busy1", 32'(busy_b), 32'h0);
        // B: ramp request 6 saturates to 5 == cur -> no-op
        code_b = 3'd6; vld_b = 1;
        tick();
        vld_b = 0;
        chk("sat_noop_done", 32'(done_b), 32'h1);
        chk("sat_noop_busy", 32'(busy_b), 32'h0);
        chk("sat_noop_seg", 32'(seg_b), 32'h1f);
        // B: ramp 5 -> 3 at STEP_CYC=2, steps at E0+2, E0+4
        code_b = 3'd3; vld_b = 1;
        tick();
        vld_b = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            cnt = (k < 2) ? 5 : (k < 4) ? 4 : 3;
            chk($sformatf("b_seg%0d", k), 32'(seg_b), therm(cnt));
            chk($sformatf("b_done%0d", k), 32'(done_b), 32'(k == 4));
        end

        // C: STEP_CYC=1 ramp 0 -> 8
        code_c = 4'd8; vld_c = 1;
        tick();
        vld_c = 0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            cnt = (k > 8) ? 8 : k;
            chk($sformatf("c_seg%0d", k), 32'(seg_c), therm(cnt));
            chk($sformatf("c_busy%0d", k), 32'(busy_c), 32'(k < 8));
            chk($sformatf("c_done%0d", k), 32'(done_c), 32'(k == 8));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
